// File: rtl/flash_bus_arbiter_pkg.sv
// Shared widths and FSM state encoding for the flash bus arbiter.
package flash_bus_arbiter_pkg;

  localparam int WB_ADDR_W    = 32;  // master/slave byte address width
  localparam int WB_DATA_W    = 32;  // master data width
  localparam int FLASH_DATA_W = 16;  // flash halfword width

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_GAP  = 3'd2,
    ST_HI   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/flash_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the master
// that was not granted last time wins.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  // Combinational grant selection
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/flash_bus_arbiter.sv
// Shares one 16-bit flash slave between two 32-bit masters (m0 fetch, m1 data).
// Reads are split into low/high halfword accesses with a one-cycle strobe gap;
// writes are a single halfword access. Each slave access is bounded by a timeout.
module flash_bus_arbiter
  import flash_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int DATA_W  = WB_DATA_W,
  parameter int HW_W    = FLASH_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m0_select_i,
  input  logic              m0_we_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  input  logic              m1_select_i,
  input  logic              m1_we_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [HW_W-1:0]   s_data_o,
  input  logic [HW_W-1:0]   s_data_i,
  output logic              s_select_o,
  output logic              s_we_o,
  input  logic              s_ack_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Registered state
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_grant;   // 0 = m0, 1 = m1
  logic                r_last;    // master granted most recently
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [HW_W-1:0]     r_wdata;
  logic [HW_W-1:0]     r_lo;
  logic [ADDR_W-1:0]   r_s_addr;
  logic [HW_W-1:0]     r_s_data;
  logic                r_s_sel;
  logic                r_s_we;
  logic                r_m0_ack, r_m0_err, r_m1_ack, r_m1_err;
  logic [DATA_W-1:0]   r_m0_data, r_m1_data;

  // Next-state values
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_grant_nxt, w_last_nxt, w_we_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt, w_s_addr_nxt;
  logic [HW_W-1:0]     w_wdata_nxt, w_lo_nxt, w_s_data_nxt;
  logic                w_s_sel_nxt, w_s_we_nxt;
  logic                w_m0_ack_nxt, w_m0_err_nxt, w_m1_ack_nxt, w_m1_err_nxt;
  logic [DATA_W-1:0]   w_m0_data_nxt, w_m1_data_nxt;
  logic                w_fin, w_fin_err;
  logic [DATA_W-1:0]   w_fin_data;
  logic [1:0]          w_gnt;
  logic                w_tmo;

  // Upper write-data bits never reach the halfword slave
  logic w_unused_data;
  assign w_unused_data = ^{m0_data_i[DATA_W-1:HW_W], m1_data_i[DATA_W-1:HW_W]};

  assign w_tmo = (r_cnt == CNT_W'(TIMEOUT - 1));

  rr_arb2 u_arb (
    .i_req  ({m1_select_i, m0_select_i}),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  // Next-state and registered-output computation
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last;
    w_addr_nxt    = r_addr;
    w_we_nxt      = r_we;
    w_wdata_nxt   = r_wdata;
    w_lo_nxt      = r_lo;
    w_s_addr_nxt  = r_s_addr;
    w_s_data_nxt  = r_s_data;
    w_s_sel_nxt   = r_s_sel;
    w_s_we_nxt    = r_s_we;
    w_m0_ack_nxt  = 1'b0;
    w_m0_err_nxt  = 1'b0;
    w_m1_ack_nxt  = 1'b0;
    w_m1_err_nxt  = 1'b0;
    w_m0_data_nxt = r_m0_data;
    w_m1_data_nxt = r_m1_data;
    w_fin         = 1'b0;
    w_fin_err     = 1'b0;
    w_fin_data    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt != 2'b00) begin
          w_grant_nxt  = w_gnt[1];
          w_addr_nxt   = w_gnt[1] ? m1_addr_i : m0_addr_i;
          w_we_nxt     = w_gnt[1] ? m1_we_i : m0_we_i;
          w_wdata_nxt  = w_gnt[1] ? m1_data_i[HW_W-1:0] : m0_data_i[HW_W-1:0];
          // Reads start at the word-aligned low halfword; writes go where asked
          w_s_addr_nxt = w_we_nxt ? w_addr_nxt : {w_addr_nxt[ADDR_W-1:2], 2'b00};
          w_s_data_nxt = w_wdata_nxt;
          w_s_we_nxt   = w_we_nxt;
          w_s_sel_nxt  = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_LO;
        end else begin
          w_s_sel_nxt  = 1'b0;
        end
      end
      ST_LO: begin
        if (s_ack_i) begin
          if (r_we) begin
            w_fin       = 1'b1;
          end else begin
            w_lo_nxt    = s_data_i;
            w_s_sel_nxt = 1'b0;
            w_state_nxt = ST_GAP;
          end
        end else if (w_tmo) begin
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_GAP: begin
        // Strobe was low for exactly this cycle; re-assert for the high half
        w_s_sel_nxt  = 1'b1;
        w_s_addr_nxt = {r_addr[ADDR_W-1:2], 2'b10};
        w_s_we_nxt   = 1'b0;
        w_cnt_nxt    = '0;
        w_state_nxt  = ST_HI;
      end
      ST_HI: begin
        if (s_ack_i) begin
          w_fin      = 1'b1;
          w_fin_data = DATA_W'({s_data_i, r_lo});
        end else if (w_tmo) begin
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_last_nxt  = r_grant;
        w_s_sel_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_s_sel_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Completion: pulse ack/err and present data to the granted master only
    if (w_fin) begin
      w_state_nxt = ST_DONE;
      w_s_sel_nxt = 1'b0;
      w_s_we_nxt  = 1'b0;
      if (r_grant) begin
        w_m1_ack_nxt  = 1'b1;
        w_m1_err_nxt  = w_fin_err;
        w_m1_data_nxt = w_fin_data;
      end else begin
        w_m0_ack_nxt  = 1'b1;
        w_m0_err_nxt  = w_fin_err;
        w_m0_data_nxt = w_fin_data;
      end
    end else begin
      w_fin_data = w_fin_data;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_lo      <= '0;
      r_s_addr  <= '0;
      r_s_data  <= '0;
      r_s_sel   <= 1'b0;
      r_s_we    <= 1'b0;
      r_m0_ack  <= 1'b0;
      r_m0_err  <= 1'b0;
      r_m1_ack  <= 1'b0;
      r_m1_err  <= 1'b0;
      r_m0_data <= '0;
      r_m1_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_grant   <= w_grant_nxt;
      r_last    <= w_last_nxt;
      r_addr    <= w_addr_nxt;
      r_we      <= w_we_nxt;
      r_wdata   <= w_wdata_nxt;
      r_lo      <= w_lo_nxt;
      r_s_addr  <= w_s_addr_nxt;
      r_s_data  <= w_s_data_nxt;
      r_s_sel   <= w_s_sel_nxt;
      r_s_we    <= w_s_we_nxt;
      r_m0_ack  <= w_m0_ack_nxt;
      r_m0_err  <= w_m0_err_nxt;
      r_m1_ack  <= w_m1_ack_nxt;
      r_m1_err  <= w_m1_err_nxt;
      r_m0_data <= w_m0_data_nxt;
      r_m1_data <= w_m1_data_nxt;
    end
  end

  assign m0_data_o  = r_m0_data;
  assign m0_ack_o   = r_m0_ack;
  assign m0_err_o   = r_m0_err;
  assign m1_data_o  = r_m1_data;
  assign m1_ack_o   = r_m1_ack;
  assign m1_err_o   = r_m1_err;
  assign s_addr_o   = r_s_addr;
  assign s_data_o   = r_s_data;
  assign s_select_o = r_s_sel;
  assign s_we_o     = r_s_we;

endmodule
